reg_ex_mem: RTL and testbench

REG_EX_MEM -- requirements
Module: reg_ex_mem

---
 rtl/reg_ex_mem.sv | 122 ++++++++++++
 tb/tb_reg_ex_mem.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_ex_mem.sv
// EX/MEM pipeline register: captures the execute-stage slot for the memory stage,
// with stall hold, flush-to-bubble and a saturating bubble counter.
module reg_ex_mem #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_in,
  input  logic            reg_write_in,
  input  logic            mem_to_reg_in,
  input  logic            branch_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic [2:0]      func_3_bits_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic            alu_zero_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [RA_W-1:0] rd_in,
  input  logic [XLEN-1:0] branch_target_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic            valid_out,
  output logic            reg_write_out,
  output logic            mem_to_reg_out,
  output logic            branch_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic [2:0]      func_3_bits_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic            alu_zero_out,
  output logic [XLEN-1:0] rs2_data_out,
  output logic [RA_W-1:0] rd_out,
  output logic [XLEN-1:0] branch_target_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic [15:0]     bubble_count
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_to_reg;
    logic            branch;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      func_3_bits;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic [XLEN-1:0] rs2_data;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] pc_plus4;
  } slot_t;

  slot_t       slot_d, slot_q;
  logic [15:0] cnt_d, cnt_q;
  logic        bubble_s;

  // Next-state selection: reset, then flush, then stall, then normal capture.
  always_comb begin
    slot_d   = slot_q;
    bubble_s = 1'b0;
    if (reset) begin
      slot_d = '0;
    end else if (flush) begin
      slot_d   = '0;
      bubble_s = 1'b1;
    end else if (stall) begin
      slot_d = slot_q;
    end else begin
      slot_d.valid         = valid_in;
      slot_d.reg_write     = reg_write_in & valid_in;
      slot_d.mem_to_reg    = mem_to_reg_in;
      slot_d.branch        = branch_in & valid_in;
      slot_d.mem_read      = mem_read_in & valid_in;
      slot_d.mem_write     = mem_write_in & valid_in;
      slot_d.func_3_bits   = func_3_bits_in;
      slot_d.alu_result    = alu_result_in;
      slot_d.alu_zero      = alu_zero_in;
      slot_d.rs2_data      = rs2_data_in;
      slot_d.rd            = rd_in;
      slot_d.branch_target = branch_target_in;
      slot_d.pc_plus4      = pc_plus4_in;
      bubble_s             = ~valid_in;
    end
  end

  // Saturating bubble counter; reset is never counted as a bubble.
  always_comb begin
    cnt_d = cnt_q;
    if (reset) begin
      cnt_d = 16'h0000;
    end else if (bubble_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'h0001;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
    cnt_q  <= cnt_d;
  end

  assign valid_out         = slot_q.valid;
  assign reg_write_out     = slot_q.reg_write;
  assign mem_to_reg_out    = slot_q.mem_to_reg;
  assign branch_out        = slot_q.branch;
  assign mem_read_out      = slot_q.mem_read;
  assign mem_write_out     = slot_q.mem_write;
  assign func_3_bits_out   = slot_q.func_3_bits;
  assign alu_result_out    = slot_q.alu_result;
  assign alu_zero_out      = slot_q.alu_zero;
  assign rs2_data_out      = slot_q.rs2_data;
  assign rd_out            = slot_q.rd;
  assign branch_target_out = slot_q.branch_target;
  assign pc_plus4_out      = slot_q.pc_plus4;
  assign bubble_count      = cnt_q;

endmodule

// File: tb/tb_reg_ex_mem.sv
// Scoreboard bench for reg_ex_mem: driver pushes model predictions, monitor pops and compares.
module tb_reg_ex_mem;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        mtr;
    logic        br;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic        z;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] bt;
    logic [31:0] pc4;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        valid;
    logic        rw;
    logic        mtr;
    logic        br;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic        z;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] bt;
    logic [31:0] pc4;
  } stim_t;

  logic clk = 1'b0;
  logic reset, stall, flush, valid_in, reg_write_in, mem_to_reg_in, branch_in;
  logic mem_read_in, mem_write_in, alu_zero_in;
  logic [2:0]  func_3_bits_in;
  logic [31:0] alu_result_in, rs2_data_in, branch_target_in, pc_plus4_in;
  logic [4:0]  rd_in;
  logic valid_out, reg_write_out, mem_to_reg_out, branch_out, mem_read_out;
  logic mem_write_out, alu_zero_out;
  logic [2:0]  func_3_bits_out;
  logic [31:0] alu_result_out, rs2_data_out, branch_target_out, pc_plus4_out;
  logic [4:0]  rd_out;
  logic [15:0] bubble_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t sb_q[$];
  obs_t model;
  int   model_cnt = 0;

  always #5 clk = ~clk;

  reg_ex_mem dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .branch_in(branch_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .func_3_bits_in(func_3_bits_in), .alu_result_in(alu_result_in),
    .alu_zero_in(alu_zero_in), .rs2_data_in(rs2_data_in), .rd_in(rd_in),
    .branch_target_in(branch_target_in), .pc_plus4_in(pc_plus4_in),
    .valid_out(valid_out), .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .branch_out(branch_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .func_3_bits_out(func_3_bits_out), .alu_result_out(alu_result_out),
    .alu_zero_out(alu_zero_out), .rs2_data_out(rs2_data_out), .rd_out(rd_out),
    .branch_target_out(branch_target_out), .pc_plus4_out(pc_plus4_out),
    .bubble_count(bubble_count)
  );

  function automatic obs_t sample();
    obs_t o;
    o = '{valid_out, reg_write_out, mem_to_reg_out, branch_out, mem_read_out,
          mem_write_out, func_3_bits_out, alu_result_out, alu_zero_out, rs2_data_out,
          rd_out, branch_target_out, pc_plus4_out, bubble_count};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s = '0;
    s.valid = ($urandom_range(3) != 0);
    s.rw    = 1'($urandom);
    s.mtr   = 1'($urandom);
    s.br    = 1'($urandom);
    s.mr    = 1'($urandom);
    s.mw    = 1'($urandom);
    s.f3    = 3'($urandom);
    s.alu   = $urandom;
    s.z     = 1'($urandom);
    s.rs2   = $urandom;
    s.rd    = 5'($urandom);
    s.bt    = $urandom;
    s.pc4   = $urandom;
    return s;
  endfunction

  // Reference behaviour: what the stage should hold after an edge with these inputs.
  task automatic predict(input stim_t s);
    if (s.rst) begin
      model     = '0;
      model_cnt = 0;
    end else if (s.flush) begin
      model     = '0;
      model_cnt = (model_cnt < 65535) ? model_cnt + 1 : 65535;
    end else if (!s.stall) begin
      model.valid = s.valid;
      model.rw    = s.valid ? s.rw : 1'b0;
      model.br    = s.valid ? s.br : 1'b0;
      model.mr    = s.valid ? s.mr : 1'b0;
      model.mw    = s.valid ? s.mw : 1'b0;
      model.mtr   = s.mtr;
      model.f3    = s.f3;
      model.alu   = s.alu;
      model.z     = s.z;
      model.rs2   = s.rs2;
      model.rd    = s.rd;
      model.bt    = s.bt;
      model.pc4   = s.pc4;
      if (!s.valid) model_cnt = (model_cnt < 65535) ? model_cnt + 1 : 65535;
    end
    model.cnt = 16'(model_cnt);
  endtask

  task automatic step(input stim_t s);
    @(negedge clk);
    reset = s.rst; stall = s.stall; flush = s.flush; valid_in = s.valid;
    reg_write_in = s.rw; mem_to_reg_in = s.mtr; branch_in = s.br;
    mem_read_in = s.mr; mem_write_in = s.mw; func_3_bits_in = s.f3;
    alu_result_in = s.alu; alu_zero_in = s.z; rs2_data_in = s.rs2; rd_in = s.rd;
    branch_target_in = s.bt; pc_plus4_in = s.pc4;
    predict(s);
    sb_q.push_back(model);
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge presents a slot; compare it with the oldest prediction.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = sample();
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL slot: got %h expected %h", a, e);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    stim_t s;
    logic [15:0] c0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    reg_write_in = 1'b0; mem_to_reg_in = 1'b0; branch_in = 1'b0; mem_read_in = 1'b0;
    mem_write_in = 1'b0; func_3_bits_in = 3'd0; alu_result_in = 32'd0; alu_zero_in = 1'b0;
    rs2_data_in = 32'd0; rd_in = 5'd0; branch_target_in = 32'd0; pc_plus4_in = 32'd0;

    s = rand_stim(); s.rst = 1'b1; s.stall = 1'b1; s.flush = 1'b1;
    step(s); step(s);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_cnt", 32'(bubble_count), 32'd0);

    s = rand_stim(); s.valid = 1'b1; s.alu = 32'h0000_1000; s.rd = 5'd5; s.rw = 1'b1;
    step(s);
    check("capture_valid", 32'(valid_out), 32'd1);
    check("capture_alu", alu_result_out, 32'h0000_1000);
    check("capture_rd", 32'(rd_out), 32'd5);
    check("capture_rw", 32'(reg_write_out), 32'd1);

    s = rand_stim(); s.valid = 1'b1; s.alu = 32'hDEAD_BEEF;
    step(s);
    c0 = bubble_count;
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.stall = 1'b1; s.alu = 32'h1; s.valid = 1'b0;
      step(s);
    end
    check("stall_alu", alu_result_out, 32'hDEAD_BEEF);
    check("stall_cnt", 32'(bubble_count), 32'(c0));

    s = rand_stim(); s.valid = 1'b1; s.br = 1'b1; s.mw = 1'b1;
    step(s);
    check("pre_flush_br", 32'(branch_out), 32'd1);
    c0 = bubble_count;
    s = rand_stim(); s.flush = 1'b1; s.stall = 1'b1;
    step(s);
    check("flush_valid", 32'(valid_out), 32'd0);
    check("flush_br", 32'(branch_out), 32'd0);
    check("flush_mw", 32'(mem_write_out), 32'd0);
    check("flush_alu", alu_result_out, 32'd0);
    check("flush_cnt", 32'(bubble_count), 32'(c0) + 32'd1);

    c0 = bubble_count;
    s = rand_stim(); s.valid = 1'b0; s.mw = 1'b1; s.br = 1'b1; s.alu = 32'h55;
    step(s);
    check("inv_mw", 32'(mem_write_out), 32'd0);
    check("inv_br", 32'(branch_out), 32'd0);
    check("inv_alu", alu_result_out, 32'h55);
    check("inv_cnt", 32'(bubble_count), 32'(c0) + 32'd1);

    s = rand_stim(); s.valid = 1'b1;
    step(s);
    s = rand_stim(); s.stall = 1'b1;
    step(s);
    s = rand_stim(); s.rst = 1'b1; s.stall = 1'b1;
    step(s);
    check("rst_stall_outs", 32'(sample() != '0), 32'd0);
    s = rand_stim(); s.valid = 1'b1; s.rd = 5'd7;
    step(s);
    check("post_rst_rd", 32'(rd_out), 32'd7);

    for (int i = 0; i < 400; i++) begin
      s = rand_stim();
      s.rst   = ($urandom_range(39) == 0);
      s.flush = ($urandom_range(7) == 0);
      s.stall = ($urandom_range(3) == 0);
      step(s);
    end

    s = rand_stim(); s.rst = 1'b1;
    step(s);
    for (int i = 0; i < 65534; i++) begin
      s = rand_stim(); s.flush = 1'b1;
      step(s);
    end
    check("cnt_fffe", 32'(bubble_count), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.flush = 1'b1; s.stall = 1'(i);
      step(s);
    end
    check("cnt_sat", 32'(bubble_count), 32'h0000_FFFF);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #3;
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
